// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the CPU, DMA and memory-side signals of the data-memory
//          arbiter into one interface.
// Ports / signals:
//   cpu_*  : CPU M-stage request, write enable, byte flag, address, write data,
//            read data back and stall.
//   dma_*  : DMA/loader request, write enable, byte flag, address, write data,
//            grant, registered read data and read-valid pulse.
//   mem_*  : address, write data and strobes to the memory, and its
//            combinational read data.
// Modports:
//   slave  : the arbiter itself.
//   master : the environment (pipeline, DMA engine and memory).
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_byte;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic          dma_byte;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_mWrite;
  logic          mem_mRead;
  logic          mem_mByte;
  logic [DW-1:0] mem_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_byte, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_mWrite, mem_mRead, mem_mByte,
    input  mem_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_byte, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_mWrite, mem_mRead, mem_mByte,
    output mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares the single data memory between the CPU M-stage and a
//          DMA/loader requester. The CPU has priority. A wait counter forces
//          the DMA in after MAX_WAIT denied cycles, and a burst counter hands
//          the memory back to a waiting CPU after BURST DMA beats.
// Ports:
//   clk   : clock, all state updates on posedge.
//   reset : synchronous, active-low reset.
//   bus   : mem_arbiter_if.slave carrying the CPU, DMA and memory signals.
// Grants, the memory mux and cpu_stall are combinational (zero latency).
// dma_rdata and dma_rvalid are registered.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8,
  parameter int BURST    = 4
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int BW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX_V  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX_V = BW'(BURST);

  typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

  state_t         state_r;
  logic [WW-1:0]  wait_cnt_r;
  logic [BW-1:0]  burst_cnt_r;
  logic [DW-1:0]  dma_rdata_r;
  logic           dma_rvalid_r;
  logic           dma_gnt_s;
  logic           cpu_gnt_s;

  // Grant decision from the current state and the live requests.
  always_comb begin
    dma_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    if (!reset) begin
      dma_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
    end else begin
      case (state_r)
        S_CPU:   dma_gnt_s = bus.dma_req & (~bus.cpu_req | (wait_cnt_r == WAIT_MAX_V));
        S_DMA:   dma_gnt_s = bus.dma_req & (~bus.cpu_req | (burst_cnt_r < BURST_MAX_V));
        default: dma_gnt_s = 1'b0;
      endcase
      cpu_gnt_s = bus.cpu_req & ~dma_gnt_s;
    end
  end

  // Memory-side mux: the granted requester owns the bus, otherwise all zero.
  always_comb begin
    bus.mem_addr   = {AW{1'b0}};
    bus.mem_wdata  = {DW{1'b0}};
    bus.mem_mWrite = 1'b0;
    bus.mem_mRead  = 1'b0;
    bus.mem_mByte  = 1'b0;
    if (dma_gnt_s) begin
      bus.mem_addr   = bus.dma_addr;
      bus.mem_wdata  = bus.dma_wdata;
      bus.mem_mWrite = bus.dma_we;
      bus.mem_mRead  = ~bus.dma_we;
      bus.mem_mByte  = bus.dma_byte;
    end else if (cpu_gnt_s) begin
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_wdata  = bus.cpu_wdata;
      bus.mem_mWrite = bus.cpu_we;
      bus.mem_mRead  = ~bus.cpu_we;
      bus.mem_mByte  = bus.cpu_byte;
    end else begin
      bus.mem_addr   = {AW{1'b0}};
      bus.mem_wdata  = {DW{1'b0}};
      bus.mem_mWrite = 1'b0;
      bus.mem_mRead  = 1'b0;
      bus.mem_mByte  = 1'b0;
    end
  end

  // Requester-side outputs; the gating by reset is already in cpu_gnt_s.
  assign bus.cpu_rdata  = bus.mem_data;
  assign bus.cpu_stall  = reset & bus.cpu_req & ~cpu_gnt_s;
  assign bus.dma_gnt    = dma_gnt_s;
  assign bus.dma_rdata  = dma_rdata_r;
  assign bus.dma_rvalid = dma_rvalid_r;

  // Arbiter state: fsm, fairness counters and the DMA read-return register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_CPU;
      wait_cnt_r   <= {WW{1'b0}};
      burst_cnt_r  <= {BW{1'b0}};
      dma_rdata_r  <= {DW{1'b0}};
      dma_rvalid_r <= 1'b0;
    end else begin
      // The wait counter only ages while the DMA is actually being denied.
      if (dma_gnt_s) begin
        wait_cnt_r <= {WW{1'b0}};
      end else if (bus.dma_req && cpu_gnt_s) begin
        if (wait_cnt_r != WAIT_MAX_V) begin
          wait_cnt_r <= wait_cnt_r + WW'(1);
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= {WW{1'b0}};
      end

      if (dma_gnt_s) begin
        if (burst_cnt_r != BURST_MAX_V) begin
          burst_cnt_r <= burst_cnt_r + BW'(1);
        end else begin
          burst_cnt_r <= burst_cnt_r;
        end
      end else begin
        burst_cnt_r <= {BW{1'b0}};
      end

      state_r <= dma_gnt_s ? S_DMA : S_CPU;

      dma_rvalid_r <= dma_gnt_s & ~bus.dma_we;
      if (dma_gnt_s && !bus.dma_we) begin
        dma_rdata_r <= bus.mem_data;
      end else begin
        dma_rdata_r <= dma_rdata_r;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter (MAX_WAIT=8, BURST=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge that updates state.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(8), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.cpu_req   = 1'b0; bus.cpu_we   = 1'b0; bus.cpu_byte = 1'b0;
    bus.cpu_addr  = 16'h0000; bus.cpu_wdata = 16'h0000;
    bus.dma_req   = 1'b0; bus.dma_we   = 1'b0; bus.dma_byte = 1'b0;
    bus.dma_addr  = 16'h0000; bus.dma_wdata = 16'h0000;
    bus.mem_data  = 16'h0000;
  endtask

  // one cycle with no requests so the arbiter returns to S_CPU with zero counters
  task automatic idle_cycle();
    @(negedge clk);
    drive_idle();
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.cpu_addr = 16'h1111; bus.dma_addr = 16'h2222;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_dma_gnt got=%b want=0", bus.dma_gnt); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall got=%b want=0", bus.cpu_stall); end
    checks++; if ({bus.mem_mWrite, bus.mem_mRead, bus.mem_mByte} !== 3'b000) begin errors++; $display("FAIL rst_strobes got=%b want=000", {bus.mem_mWrite, bus.mem_mRead, bus.mem_mByte}); end
    checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got=%h want=0000", bus.mem_addr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b want=0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h want=0000", bus.dma_rdata); end
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.mem_data = 16'h1234;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall got=%b want=0", bus.cpu_stall); end
    checks++; if (bus.mem_mRead !== 1'b1 || bus.mem_mWrite !== 1'b0) begin errors++; $display("FAIL cpu_rd_strobe got=%b%b want=10", bus.mem_mRead, bus.mem_mWrite); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL cpu_rd_addr got=%h want=0010", bus.mem_addr); end
    checks++; if (bus.cpu_rdata !== 16'h1234) begin errors++; $display("FAIL cpu_rd_data got=%h want=1234", bus.cpu_rdata); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL cpu_rd_dma_gnt got=%b want=0", bus.dma_gnt); end
    @(posedge clk);
    idle_cycle();
  endtask

  task automatic test_dma_write_burst();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_byte = 1'b0;
      bus.dma_addr = 16'h0100 + 16'(2 * i); bus.dma_wdata = 16'hA000 + 16'(i);
      #1;
      checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL dma_wr_gnt beat=%0d got=%b want=1", i, bus.dma_gnt); end
      checks++; if (bus.mem_mWrite !== 1'b1 || bus.mem_mRead !== 1'b0) begin errors++; $display("FAIL dma_wr_strobe beat=%0d got=%b%b want=10", i, bus.mem_mWrite, bus.mem_mRead); end
      checks++; if (bus.mem_addr !== 16'h0100 + 16'(2 * i) || bus.mem_wdata !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL dma_wr_bus beat=%0d got=%h/%h want=%h/%h", i, bus.mem_addr, bus.mem_wdata, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i)); end
      @(posedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_contention();
    logic exp_cpu;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0300;
      exp_cpu = ((c % 12) < 8);
      #1;
      checks++; if (bus.dma_gnt !== ~exp_cpu) begin errors++; $display("FAIL contend_dma_gnt cycle=%0d got=%b want=%b", c, bus.dma_gnt, ~exp_cpu); end
      checks++; if (bus.cpu_stall !== ~exp_cpu) begin errors++; $display("FAIL contend_stall cycle=%0d got=%b want=%b", c, bus.cpu_stall, ~exp_cpu); end
      checks++; if (bus.mem_addr !== (exp_cpu ? 16'h0200 : 16'h0300)) begin errors++; $display("FAIL contend_addr cycle=%0d got=%h want=%h", c, bus.mem_addr, exp_cpu ? 16'h0200 : 16'h0300); end
      @(posedge clk);
    end
    idle_cycle();
  endtask

  task automatic test_dma_read();
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_byte = 1'b0; bus.dma_addr = 16'h0040; bus.mem_data = 16'hBEEF;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_mRead !== 1'b1) begin errors++; $display("FAIL dma_rd_issue got=%b%b want=11", bus.dma_gnt, bus.mem_mRead); end
    checks++; if (bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL dma_rd_addr got=%h want=0040", bus.mem_addr); end
    @(posedge clk);
    @(negedge clk);
    bus.dma_req = 1'b0; bus.mem_data = 16'h0000;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL dma_rd_rvalid got=%b want=1", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 16'hBEEF) begin errors++; $display("FAIL dma_rd_rdata got=%h want=beef", bus.dma_rdata); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL dma_rd_rvalid_drop got=%b want=0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 16'hBEEF) begin errors++; $display("FAIL dma_rd_rdata_hold got=%h want=beef", bus.dma_rdata); end
    idle_cycle();
  endtask

  task automatic test_burst_drop();
    // two uncontended beats leave the arbiter in S_DMA with burst_cnt=2
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0500;
      @(posedge clk);
    end
    @(negedge clk);
    bus.dma_req = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0600;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL drop_cpu_gnt stall/dma got=%b%b want=00", bus.cpu_stall, bus.dma_gnt); end
    checks++; if (bus.mem_addr !== 16'h0600) begin errors++; $display("FAIL drop_addr got=%h want=0600", bus.mem_addr); end
    @(posedge clk);
    // back in S_CPU with zero counters: contention now favours the CPU
    @(negedge clk);
    bus.dma_req = 1'b1;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL drop_state_cpu dma/stall got=%b%b want=00", bus.dma_gnt, bus.cpu_stall); end
    @(posedge clk);
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst();
    // eight CPU cycles, then the first DMA read beat
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0700;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0800; bus.mem_data = 16'h5A5A;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_gnts dma/stall got=%b%b want=00", bus.dma_gnt, bus.cpu_stall); end
    checks++; if ({bus.mem_mWrite, bus.mem_mRead, bus.mem_mByte} !== 3'b000) begin errors++; $display("FAIL mid_rst_strobes got=%b want=000", {bus.mem_mWrite, bus.mem_mRead, bus.mem_mByte}); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got=%b want=0", bus.dma_rvalid); end
    reset = 1'b1;
    // counters cleared: again eight CPU cycles before the DMA is forced in
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (bus.dma_gnt !== (c == 8)) begin errors++; $display("FAIL mid_rst_resume cycle=%0d got=%b want=%b", c, bus.dma_gnt, c == 8); end
      @(posedge clk);
      @(negedge clk);
    end
    drive_idle();
    @(posedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_cpu_read();
    test_dma_write_burst();
    test_contention();
    test_dma_read();
    test_burst_drop();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
